// File: rtl/namuru_corr_pkg.sv
// Shared constants for the tracking-channel correlator: default widths,
// chip-to-sign mapping and saturation bounds for the default accumulator width.
package namuru_corr_pkg;

    localparam int IN_W_DEF  = 3;
    localparam int ACC_W_DEF = 16;
    localparam int CNT_W_DEF = 12;

    // A chip value of 1 negates the sample; 0 passes it through.
    localparam logic CHIP_NEG = 1'b1;

    localparam int ACC_SAT_MAX = (2 ** (ACC_W_DEF - 1)) - 1;
    localparam int ACC_SAT_MIN = -(2 ** (ACC_W_DEF - 1));

endpackage

// File: rtl/epl_acc_lane.sv
// One signed saturating integrate-and-dump accumulator plus its latched output
// register; the top instantiates one per early/prompt/late x I/Q combination.
module epl_acc_lane
    import namuru_corr_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clear,
    input  logic                    sample_enable,
    input  logic                    dump,
    input  logic                    chip,
    input  logic signed [IN_W-1:0]  x,
    output logic signed [ACC_W-1:0] sum_out
);

    // Bounds expressed one bit wider than the accumulator so the raw sum can exceed them.
    localparam logic signed [ACC_W:0] SAT_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {2'b11, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W:0]   x_ext;
    logic signed [ACC_W:0]   term;
    logic signed [ACC_W:0]   raw_sum;
    logic signed [ACC_W:0]   sat_sum;

    always_comb begin
        x_ext   = {{(ACC_W+1-IN_W){x[IN_W-1]}}, x};
        // Extra headroom bit lets the most-negative sample negate to its positive magnitude.
        term    = (chip == CHIP_NEG) ? -x_ext : x_ext;
        raw_sum = {acc[ACC_W-1], acc} + term;
        sat_sum = raw_sum;
        if (raw_sum > SAT_MAX) begin
            sat_sum = SAT_MAX;
        end else if (raw_sum < SAT_MIN) begin
            sat_sum = SAT_MIN;
        end
        acc_next = sample_enable ? sat_sum[ACC_W-1:0] : acc;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc     <= '0;
            sum_out <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (dump) begin
            sum_out <= acc_next;
            acc     <= '0;
        end else begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/epl_accumulator.sv
// Early/prompt/late I/Q correlator for one channel: six integrate-and-dump lanes,
// a per-dump sample counter, and the fresh-data / overrun flags read by firmware.
module epl_accumulator
    import namuru_corr_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    prn_key_enable,
    input  logic                    sample_enable,
    input  logic signed [IN_W-1:0]  i_bb,
    input  logic signed [IN_W-1:0]  q_bb,
    input  logic                    early,
    input  logic                    prompt,
    input  logic                    late,
    input  logic                    dump_enable,
    input  logic                    read_ack,
    output logic signed [ACC_W-1:0] i_early,
    output logic signed [ACC_W-1:0] q_early,
    output logic signed [ACC_W-1:0] i_prompt,
    output logic signed [ACC_W-1:0] q_prompt,
    output logic signed [ACC_W-1:0] i_late,
    output logic signed [ACC_W-1:0] q_late,
    output logic [CNT_W-1:0]        sample_count,
    output logic                    accum_valid,
    output logic                    new_data,
    output logic                    overrun
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             dump;

    // prn_key_enable masks any coincident dump so lanes and flags see one consistent view.
    assign dump = dump_enable && !prn_key_enable;

    always_comb begin
        cnt_next = cnt;
        if (sample_enable && (cnt != {CNT_W{1'b1}})) begin
            cnt_next = cnt + 1'b1;
        end
    end

    epl_acc_lane #(.IN_W(IN_W), .ACC_W(ACC_W)) u_i_early (
        .clk(clk), .rstn(rstn), .clear(prn_key_enable), .sample_enable(sample_enable),
        .dump(dump), .chip(early), .x(i_bb), .sum_out(i_early)
    );
    epl_acc_lane #(.IN_W(IN_W), .ACC_W(ACC_W)) u_q_early (
        .clk(clk), .rstn(rstn), .clear(prn_key_enable), .sample_enable(sample_enable),
        .dump(dump), .chip(early), .x(q_bb), .sum_out(q_early)
    );
    epl_acc_lane #(.IN_W(IN_W), .ACC_W(ACC_W)) u_i_prompt (
        .clk(clk), .rstn(rstn), .clear(prn_key_enable), .sample_enable(sample_enable),
        .dump(dump), .chip(prompt), .x(i_bb), .sum_out(i_prompt)
    );
    epl_acc_lane #(.IN_W(IN_W), .ACC_W(ACC_W)) u_q_prompt (
        .clk(clk), .rstn(rstn), .clear(prn_key_enable), .sample_enable(sample_enable),
        .dump(dump), .chip(prompt), .x(q_bb), .sum_out(q_prompt)
    );
    epl_acc_lane #(.IN_W(IN_W), .ACC_W(ACC_W)) u_i_late (
        .clk(clk), .rstn(rstn), .clear(prn_key_enable), .sample_enable(sample_enable),
        .dump(dump), .chip(late), .x(i_bb), .sum_out(i_late)
    );
    epl_acc_lane #(.IN_W(IN_W), .ACC_W(ACC_W)) u_q_late (
        .clk(clk), .rstn(rstn), .clear(prn_key_enable), .sample_enable(sample_enable),
        .dump(dump), .chip(late), .x(q_bb), .sum_out(q_late)
    );

    // Firmware handshake: new_data rises on each dump and stays high until a
    // read_ack cycle; a dump while new_data is still high (and unacknowledged
    // that same cycle) raises overrun, which only a channel restart clears.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt          <= '0;
            sample_count <= '0;
            accum_valid  <= 1'b0;
            new_data     <= 1'b0;
            overrun      <= 1'b0;
        end else if (prn_key_enable) begin
            cnt         <= '0;
            accum_valid <= 1'b0;
            new_data    <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            accum_valid <= dump;
            if (dump) begin
                sample_count <= cnt_next;
                cnt          <= '0;
                new_data     <= 1'b1;
                if (new_data && !read_ack) begin
                    overrun <= 1'b1;
                end
            end else begin
                cnt <= cnt_next;
                if (read_ack) begin
                    new_data <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_epl_accumulator.sv
// Directed bench for epl_accumulator (8-bit accumulators so saturation is reachable);
// dumps push expected words to a queue that a monitor pops on each accum_valid.
module tb_epl_accumulator;

    localparam int IN_W  = 3;
    localparam int ACC_W = 8;
    localparam int CNT_W = 12;
    localparam int W     = 6 * ACC_W + CNT_W;

    logic                    clk;
    logic                    rstn;
    logic                    prn_key_enable;
    logic                    sample_enable;
    logic signed [IN_W-1:0]  i_bb;
    logic signed [IN_W-1:0]  q_bb;
    logic                    early;
    logic                    prompt;
    logic                    late;
    logic                    dump_enable;
    logic                    read_ack;
    logic signed [ACC_W-1:0] i_early;
    logic signed [ACC_W-1:0] q_early;
    logic signed [ACC_W-1:0] i_prompt;
    logic signed [ACC_W-1:0] q_prompt;
    logic signed [ACC_W-1:0] i_late;
    logic signed [ACC_W-1:0] q_late;
    logic [CNT_W-1:0]        sample_count;
    logic                    accum_valid;
    logic                    new_data;
    logic                    overrun;

    epl_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .prn_key_enable(prn_key_enable),
        .sample_enable(sample_enable), .i_bb(i_bb), .q_bb(q_bb),
        .early(early), .prompt(prompt), .late(late),
        .dump_enable(dump_enable), .read_ack(read_ack),
        .i_early(i_early), .q_early(q_early), .i_prompt(i_prompt),
        .q_prompt(q_prompt), .i_late(i_late), .q_late(q_late),
        .sample_count(sample_count), .accum_valid(accum_valid),
        .new_data(new_data), .overrun(overrun)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int pass_cnt  = 0;
    int total_cnt = 0;
    int m_acc[6];
    int m_cnt;
    logic m_nd;
    logic m_ov;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic int sat(input int v);
        int lo;
        int hi;
        hi = (1 << (ACC_W - 1)) - 1;
        lo = -(1 << (ACC_W - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 6; k++) m_acc[k] = 0;
        m_cnt = 0;
        m_nd  = 1'b0;
        m_ov  = 1'b0;
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic se, input int i, input int q,
                        input logic e, input logic p, input logic l,
                        input logic de, input logic ra, input logic pk);
        int nxt[6];
        int ncnt;
        int x;
        logic ch;
        logic [W-1:0] w;
        sample_enable  = se;
        i_bb           = IN_W'(i);
        q_bb           = IN_W'(q);
        early          = e;
        prompt         = p;
        late           = l;
        dump_enable    = de;
        read_ack       = ra;
        prn_key_enable = pk;
        if (pk) begin
            for (int k = 0; k < 6; k++) m_acc[k] = 0;
            m_cnt = 0;
            m_nd  = 1'b0;
            m_ov  = 1'b0;
        end else begin
            for (int k = 0; k < 6; k++) begin
                x  = (k % 2 == 0) ? i : q;
                ch = (k < 2) ? e : ((k < 4) ? p : l);
                nxt[k] = se ? sat(m_acc[k] + (ch ? -x : x)) : m_acc[k];
            end
            ncnt = (se && m_cnt < 4095) ? m_cnt + 1 : m_cnt;
            if (de) begin
                w = '0;
                for (int k = 0; k < 6; k++) w[W-1-ACC_W*k -: ACC_W] = ACC_W'(nxt[k]);
                w[CNT_W-1:0] = CNT_W'(ncnt);
                exp_q.push_back(w);
                if (m_nd && !ra) m_ov = 1'b1;
                m_nd = 1'b1;
                for (int k = 0; k < 6; k++) m_acc[k] = 0;
                m_cnt = 0;
            end else begin
                for (int k = 0; k < 6; k++) m_acc[k] = nxt[k];
                m_cnt = ncnt;
                if (ra) m_nd = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        sample_enable  = 1'b0;
        dump_enable    = 1'b0;
        read_ack       = 1'b0;
        prn_key_enable = 1'b0;
        // Leave one idle cycle so accum_valid is seen as a single-cycle pulse.
        @(posedge clk);
        #1;
    endtask

    task automatic samples(input int n, input int i, input int q,
                           input logic e, input logic p, input logic l);
        for (int s = 0; s < n; s++) step(1'b1, i, q, e, p, l, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic dump_and_ack();
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_new_data"}, {63'd0, new_data}, {63'd0, m_nd});
        check({tag, "_overrun"}, {63'd0, overrun}, {63'd0, m_ov});
    endtask

    // ---------------- monitor: pop one expected word per accum_valid ----------------
    always @(negedge clk) begin
        if (rstn && accum_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_accum_valid", 64'sd1, 64'sd0);
            end else begin
                check("dump_word",
                      {{(64-W){1'b0}}, i_early, q_early, i_prompt, q_prompt,
                       i_late, q_late, sample_count},
                      {{(64-W){1'b0}}, exp_q.pop_front()});
            end
        end
    end

    // ---------------- directed sequence ----------------
    logic signed [ACC_W-1:0] held_i_early;

    initial begin
        rstn = 1'b0;
        prn_key_enable = 1'b0; sample_enable = 1'b0; i_bb = '0; q_bb = '0;
        early = 1'b0; prompt = 1'b0; late = 1'b0; dump_enable = 1'b0; read_ack = 1'b0;
        model_reset();
        #12;
        check("reset_i_early", i_early, 0);
        check("reset_sample_count", {52'd0, sample_count}, 0);
        check("reset_flags", {61'd0, accum_valid, new_data, overrun}, 0);
        #9 rstn = 1'b1;
        @(posedge clk); #1;

        // 1: ten samples +3/-2, all chips 0
        samples(10, 3, -2, 1'b0, 1'b0, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t1_i_early", i_early, 30);
        check("t1_q_late", q_late, -20);
        check("t1_count", {52'd0, sample_count}, 10);
        check_flags("t1");
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_flags("t1_ack");

        // 2: prompt chip 1 only
        samples(10, 3, -2, 1'b0, 1'b1, 1'b0);
        dump_and_ack();
        check("t2_i_prompt", i_prompt, -30);
        check("t2_q_prompt", q_prompt, 20);
        check("t2_i_early", i_early, 30);

        // 3: saturation in both directions
        samples(50, 3, 0, 1'b0, 1'b0, 1'b0);
        dump_and_ack();
        check("t3_i_early_pos_sat", i_early, 127);
        samples(40, -4, 0, 1'b1, 1'b0, 1'b0);
        dump_and_ack();
        check("t3_i_early_negmax", i_early, 127);
        check("t3_i_prompt_neg_sat", i_prompt, -128);

        // 4: sample coincident with dump, then a fresh period
        samples(5, 1, 0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t4_i_early", i_early, 6);
        check("t4_count", {52'd0, sample_count}, 6);
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        samples(2, 1, 0, 1'b0, 1'b0, 1'b0);
        dump_and_ack();
        check("t4_i_early_next", i_early, 2);
        check("t4_count_next", {52'd0, sample_count}, 2);

        // 5: overrun, acknowledge, dump+ack collision, channel restart
        samples(3, 2, 1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        samples(1, 1, 1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t5_overrun", {63'd0, overrun}, 1);
        check_flags("t5_two_dumps");
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t5_new_data_acked", {63'd0, new_data}, 0);
        check_flags("t5_ack");
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_flags("t5_dump_ack_same");
        held_i_early = i_early;
        samples(2, 3, 3, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("t5_prn_overrun", {63'd0, overrun}, 0);
        check_flags("t5_prn");
        check("t5_prn_hold", i_early, held_i_early);
        samples(1, 1, 0, 1'b0, 1'b0, 1'b0);
        dump_and_ack();
        check("t5_after_prn_i_early", i_early, 1);

        // 6: asynchronous reset mid-integration
        samples(3, 2, 2, 1'b0, 1'b0, 1'b0);
        #2 rstn = 1'b0;
        #1;
        check("t6_async_i_early", i_early, 0);
        check("t6_async_count", {52'd0, sample_count}, 0);
        check("t6_async_flags", {61'd0, accum_valid, new_data, overrun}, 0);
        model_reset();
        #3 rstn = 1'b1;
        @(posedge clk); #1;
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t6_dump_zero", i_early, 0);
        check("t6_count_zero", {52'd0, sample_count}, 0);
        check_flags("t6");

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/epl_accumulator.md
Name: epl_accumulator

Overview:
Downstream correlator stage for one tracking channel. It consumes the early, prompt and late C/A chips and dump_enable from the channel code generator, plus the carrier-wiped I/Q baseband samples. It forms six integrate-and-dump sums: I and Q for each of early, prompt and late. At every dump_enable it latches the six sums into output registers for firmware readout and flags fresh data and overruns.

Parameters:
IN_W, 3, width of signed two's-complement i_bb/q_bb samples
ACC_W, 16, width of each signed accumulator and output register
CNT_W, 12, width of per-dump sample counter (max 4095 samples per C/A period)

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
prn_key_enable  in  1  channel restart pulse; clears accumulators, counters and flags
sample_enable  in  1  one-cycle pulse, i_bb/q_bb valid
i_bb  in  IN_W  signed in-phase baseband sample
q_bb  in  IN_W  signed quadrature baseband sample
early  in  1  early chip
prompt  in  1  prompt chip
late  in  1  late chip
dump_enable  in  1  one-cycle pulse at C/A code-period boundary
read_ack  in  1  firmware read strobe; clears new_data
i_early, q_early, i_prompt, q_prompt, i_late, q_late  out  ACC_W each  latched signed sums
sample_count  out  CNT_W  samples integrated into latched sums
accum_valid  out  1  one-cycle pulse, outputs updated this cycle
new_data  out  1  sticky: latched sums not yet acknowledged
overrun  out  1  sticky: dump occurred while new_data was set

Behaviour:
- Reset (rstn low, async): all accumulators, output registers, sample_count, the internal sample counter, accum_valid, new_data and overrun go to 0.
- Chip mapping: chip=0 means +1, chip=1 means -1. On sample_enable, each accumulator adds x when its chip is 0 and subtracts x when its chip is 1, where x is i_bb for the I sums and q_bb for the Q sums.
- Arithmetic:
  - Sign-extend samples to ACC_W+1 bits.
  - Saturate each sum to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; no wrap-around.
  - Negating the most-negative sample (-4 for IN_W=3) gives +4 before the add.
- The internal sample counter increments on each sample_enable and saturates at 2^CNT_W-1.
- Dump, registered with 1-cycle latency:
  - On the cycle dump_enable is high, each output register loads the accumulator plus that cycle's contribution if sample_enable is also high.
  - sample_count loads the counter value, including any same-cycle sample.
  - Accumulators and counter load 0.
  - accum_valid is high for exactly the following cycle, aligned with the new output values.
- new_data is set on the dump edge and cleared by read_ack. If dump_enable and read_ack coincide, set wins.
- overrun is set when dump_enable arrives while new_data=1 and read_ack=0. It is cleared only by prn_key_enable or reset. The output registers are overwritten regardless.
- prn_key_enable (synchronous, highest priority over everything except rstn):
  - Clears the accumulators, the counter, new_data and overrun.
  - Output registers hold their previous values.
  - A coincident dump_enable or sample_enable is ignored.
- When sample_enable is absent, the accumulators hold.
- Back-to-back dump_enable on consecutive cycles is legal: the second dump latches 0 (or the single same-cycle sample) and produces a second accum_valid.
- There is no state machine beyond the integrate/dump control: the block is continuously integrating, and dump is an event, not a state.

Decomposition:
- Shared package (namuru_corr_pkg) holds IN_W/ACC_W/CNT_W defaults, the chip-to-sign mapping constant, and the saturation min/max constants.
- One natural sub-module: epl_acc_lane. It contains one signed saturating integrate-and-dump accumulator with its output register, and is instantiated six times.
- The top level holds the sample counter, the dump/valid timing and the new_data/overrun flags.

Test Plan:
1. Reset, then 10 samples i_bb=+3, q_bb=-2 with early=prompt=late=0, then dump: i_*=30, q_*=-20, sample_count=10, accum_valid 1 cycle after dump, new_data=1.
2. Same samples with prompt=1 only: i_prompt=-30, q_prompt=+20; early and late sums as in test 1.
3. Saturation with ACC_W=8: 50 samples i_bb=+3 with chip 0 gives i_early=127, not wrapped; i_bb=-4 with chip 1 repeated 40 times gives +127.
4. Sample and dump in the same cycle after 5 samples of +1: latched i_early=6 and sample_count=6; the next period starts at 0 and a later dump after 2 samples gives 2.
5. Two dumps with no read_ack: overrun=1 and new_data=1. Then read_ack: new_data=0 and overrun stays 1. prn_key_enable clears overrun and leaves outputs unchanged.
6. Assert rstn low mid-integration, asynchronously between clock edges: all outputs are 0 immediately. After release, a dump with no samples latches 0 and sample_count=0.
